// File: rtl/chain_tx_scheduler.sv
// Round-robin packet scheduler in front of a byte-wide UART serializer.
// Frames each granted packet as SOF, ID, payload, CHK and generates the baud tick.
module chain_tx_scheduler #(
    parameter int         NUM_REQ = 2,
    parameter int         CLK_DIV = 434,
    parameter int         MAX_LEN = 255,
    parameter logic [7:0] SOF     = 8'h7E
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic                   ser_ready,
    output logic                   ser_load,
    output logic [7:0]             ser_data,
    output logic                   baud_tick,
    output logic [2:0]             grant_id,
    output logic                   busy,
    output logic                   err_len
);

    // state    | meaning
    // ST_IDLE  | no packet; pick next requester round-robin
    // ST_SOF   | send start-of-frame byte
    // ST_ID    | send requester index
    // ST_PAY   | forward payload bytes from the granted requester
    // ST_CHK   | send XOR of ID and payload
    // ST_GUARD | one dead cycle after every load, then go to ret
    typedef enum logic [2:0] {ST_IDLE, ST_SOF, ST_ID, ST_PAY, ST_CHK, ST_GUARD} state_t;

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] baud_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                           baud_cnt <= '0;
        else if (baud_cnt == CW'(CLK_DIV-1)) baud_cnt <= '0;
        else                                 baud_cnt <= baud_cnt + CW'(1);
    end

    assign baud_tick = (baud_cnt == CW'(CLK_DIV-1));

    state_t       state, state_nxt, ret, ret_nxt;
    logic [7:0]   chk, chk_nxt, len, len_nxt, ser_hold, load_byte;
    logic [2:0]   rr, rr_nxt, grant_nxt, arb_idx;
    logic         busy_nxt, arb_found;
    logic         g_valid, g_last, len_hit;
    logic [7:0]   g_data;
    logic [NUM_REQ-1:0] g_onehot;

    // first valid requester at or after the round-robin pointer
    always_comb begin
        arb_idx   = '0;
        arb_found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!arb_found && req_valid[j] && ((int'(rr) + i) % NUM_REQ) == j) begin
                    arb_found = 1'b1;
                    arb_idx   = 3'(j);
                end
            end
        end
    end

    always_comb begin
        g_valid  = 1'b0;
        g_last   = 1'b0;
        g_data   = '0;
        g_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == 3'(i)) begin
                g_valid     = req_valid[i];
                g_last      = req_last[i];
                g_data      = req_data[8*i +: 8];
                g_onehot[i] = 1'b1;
            end
        end
    end

    assign len_hit = (({1'b0, len} + 9'd1) == 9'(MAX_LEN));

    always_comb begin
        state_nxt = state;
        ret_nxt   = ret;
        chk_nxt   = chk;
        len_nxt   = len;
        rr_nxt    = rr;
        grant_nxt = grant_id;
        busy_nxt  = busy;
        req_ready = '0;
        ser_load  = 1'b0;
        load_byte = ser_hold;
        err_len   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (arb_found) begin
                    grant_nxt = arb_idx;
                    busy_nxt  = 1'b1;
                    chk_nxt   = '0;
                    len_nxt   = '0;
                    state_nxt = ST_SOF;
                end
            end
            ST_SOF: begin
                if (ser_ready) begin
                    ser_load  = 1'b1;
                    load_byte = SOF;
                    ret_nxt   = ST_ID;
                    state_nxt = ST_GUARD;
                end
            end
            ST_ID: begin
                if (ser_ready) begin
                    ser_load  = 1'b1;
                    load_byte = {5'b0, grant_id};
                    chk_nxt   = chk ^ {5'b0, grant_id};
                    ret_nxt   = ST_PAY;
                    state_nxt = ST_GUARD;
                end
            end
            ST_PAY: begin
                if (ser_ready && g_valid) begin
                    req_ready = g_onehot;
                    ser_load  = 1'b1;
                    load_byte = g_data;
                    chk_nxt   = chk ^ g_data;
                    len_nxt   = len + 8'd1;
                    err_len   = len_hit && !g_last;
                    ret_nxt   = (g_last || len_hit) ? ST_CHK : ST_PAY;
                    state_nxt = ST_GUARD;
                end
            end
            ST_CHK: begin
                if (ser_ready) begin
                    ser_load  = 1'b1;
                    load_byte = chk;
                    rr_nxt    = (grant_id == 3'(NUM_REQ-1)) ? 3'd0 : grant_id + 3'd1;
                    ret_nxt   = ST_IDLE;
                    state_nxt = ST_GUARD;
                end
            end
            ST_GUARD: begin
                state_nxt = ret;
                if (ret == ST_IDLE) busy_nxt = 1'b0;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign ser_data = load_byte;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            ret      <= ST_IDLE;
            chk      <= '0;
            len      <= '0;
            rr       <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
            ser_hold <= '0;
        end else begin
            state    <= state_nxt;
            ret      <= ret_nxt;
            chk      <= chk_nxt;
            len      <= len_nxt;
            rr       <= rr_nxt;
            grant_id <= grant_nxt;
            busy     <= busy_nxt;
            if (ser_load) ser_hold <= load_byte;
        end
    end

endmodule

// File: tb/tb_chain_tx_scheduler.sv
// Scoreboard bench for chain_tx_scheduler: generator pushes expected frames per
// requester, an independent monitor predicts the round-robin owner and checks bytes.
module tb_chain_tx_scheduler;
    localparam int         N       = 2;
    localparam int         CLK_DIV = 7;
    localparam int         MAX_LEN = 4;
    localparam logic [7:0] SOF     = 8'h7E;

    logic           clk, reset;
    logic [N-1:0]   req_valid, req_last, req_ready;
    logic [8*N-1:0] req_data;
    logic           ser_ready, ser_load, baud_tick, busy, err_len;
    logic [7:0]     ser_data;
    logic [2:0]     grant_id;

    chain_tx_scheduler #(.NUM_REQ(N), .CLK_DIV(CLK_DIV), .MAX_LEN(MAX_LEN), .SOF(SOF)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .ser_ready(ser_ready),
        .ser_load(ser_load), .ser_data(ser_data), .baud_tick(baud_tick),
        .grant_id(grant_id), .busy(busy), .err_len(err_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // per-requester stimulus and expected frames
    logic [7:0] pay_q[N][$];
    bit         last_q[N][$];
    bit         first_q[N][$];
    logic [7:0] exp_q[N][$];
    int         len_q[N][$];
    bit         trunc_q[N][$];
    logic [7:0] tmp_q[$];

    logic       v_r[N];
    logic [7:0] d_r[N];
    logic       l_r[N];
    bit         flush = 0, gap_en = 0, mon_in_frame = 0;
    int         ser_mode = 0, last_busy_len = 0, err_total = 0;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_valid[i]       = v_r[i];
            req_data[8*i +: 8] = d_r[i];
            req_last[i]        = l_r[i];
        end
    end

    // a packet longer than MAX_LEN is sent as several frames
    task automatic gen_pkt(input int r);
        int         len, clen;
        logic [7:0] x, b;
        len = tmp_q.size();
        for (int c = 0; c < len; c += MAX_LEN) begin
            clen = (len - c < MAX_LEN) ? len - c : MAX_LEN;
            x = 8'(r);
            exp_q[r].push_back(SOF);
            exp_q[r].push_back(8'(r));
            for (int k = 0; k < clen; k++) begin
                b = tmp_q[c+k];
                exp_q[r].push_back(b);
                x = x ^ b;
                pay_q[r].push_back(b);
                last_q[r].push_back(c + k == len - 1);
                first_q[r].push_back(k == 0);
            end
            exp_q[r].push_back(x);
            len_q[r].push_back(clen);
            trunc_q[r].push_back(c + clen < len);
        end
    endtask

    for (genvar gi = 0; gi < N; gi++) begin : g_drv
        initial begin
            int gap;
            bit acc;
            gap = 0;
            v_r[gi] = 1'b0; d_r[gi] = '0; l_r[gi] = 1'b0;
            forever begin
                @(negedge clk);
                acc = v_r[gi] && req_ready[gi];
                @(posedge clk);
                #1;
                if (flush) begin
                    v_r[gi] = 1'b0;
                    gap = 0;
                end else begin
                    if (acc) begin
                        void'(pay_q[gi].pop_front());
                        void'(last_q[gi].pop_front());
                        void'(first_q[gi].pop_front());
                        v_r[gi] = 1'b0;
                        if (pay_q[gi].size() > 0)
                            gap = (first_q[gi][0] || !gap_en) ? 0 : int'($urandom_range(0, 2));
                    end
                    if (!v_r[gi] && pay_q[gi].size() > 0) begin
                        if (gap > 0) gap--;
                        else begin
                            v_r[gi] = 1'b1;
                            d_r[gi] = pay_q[gi][0];
                            l_r[gi] = last_q[gi][0];
                        end
                    end
                end
            end
        end
    end

    initial begin
        ser_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ser_mode)
                0:       ser_ready = 1'b1;
                1:       ser_ready = ($urandom_range(0, 3) != 0);
                default: ser_ready = 1'b0;
            endcase
        end
    end

    // monitor: owner of each new frame is the next requester with frames pending
    initial begin
        int g, rem, flen, ferr, idx, rr_m;
        bit ftr, prev_load;
        logic [7:0] last_d;
        g = 0; rem = 0; flen = 0; ferr = 0; rr_m = 0; ftr = 0; prev_load = 0; last_d = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                mon_in_frame = 0; rr_m = 0; last_d = '0; prev_load = 0;
                continue;
            end
            if (ser_load) begin
                check("load_spacing", int'(prev_load), 0);
                check("load_while_ready", int'(ser_ready), 1);
                if (!mon_in_frame) begin
                    g = -1;
                    for (int k = 0; k < N; k++)
                        if (g < 0 && len_q[(rr_m + k) % N].size() > 0) g = (rr_m + k) % N;
                    if (g < 0) begin
                        vectors++; miscompares++;
                        $display("FAIL unexpected_frame: got byte %0h, expected no load", ser_data);
                    end else begin
                        flen = len_q[g].pop_front();
                        ftr  = trunc_q[g].pop_front();
                        rem  = flen + 3;
                        ferr = 0;
                        mon_in_frame = 1;
                    end
                end
            end
            if (err_len) ferr++;
            if (ser_load && mon_in_frame) begin
                idx = flen + 3 - rem;
                check("ser_data", int'(ser_data), int'(exp_q[g].pop_front()));
                check("grant_id", int'(grant_id), g);
                check("busy", int'(busy), 1);
                check("req_ready", int'(req_ready), (idx >= 2 && idx < flen + 2) ? (1 << g) : 0);
                rem--;
                if (rem == 0) begin
                    mon_in_frame = 0;
                    check("err_len_count", ferr, int'(ftr));
                    rr_m = (g + 1) % N;
                end
            end else if (!ser_load) begin
                check("ser_data_hold", int'(ser_data), int'(last_d));
                check("ready_no_load", int'(req_ready), 0);
            end
            if (ser_load) last_d = ser_data;
            prev_load = ser_load;
        end
    end

    initial begin
        int cnt;
        cnt = -1;
        forever begin
            @(negedge clk);
            if (reset) cnt = -1;
            else begin
                if (cnt >= 0) cnt++;
                if (baud_tick) begin
                    if (cnt >= 0) check("baud_period", cnt, CLK_DIV);
                    cnt = 0;
                end
            end
        end
    end

    initial begin
        int bl;
        bl = 0;
        forever begin
            @(negedge clk);
            if (!reset && err_len) err_total++;
            if (busy) bl++;
            else begin
                if (bl > 0) last_busy_len = bl;
                bl = 0;
            end
        end
    end

    function automatic bit all_empty();
        for (int r = 0; r < N; r++)
            if (pay_q[r].size() || exp_q[r].size() || len_q[r].size()) return 0;
        return 1;
    endfunction

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!(all_empty() && !mon_in_frame && !busy) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20000) begin
            vectors++; miscompares++;
            $display("FAIL %s_timeout: got busy after %0d cycles, expected idle", name, n);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_ready(input int r, input string name);
        int n;
        n = 0;
        while (!req_ready[r] && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            vectors++; miscompares++;
            $display("FAIL %s_timeout: got no req_ready, expected one", name);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ser_load"}, int'(ser_load), 0);
        check({tag, "_ser_data"}, int'(ser_data), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_grant_id"}, int'(grant_id), 0);
        check({tag, "_req_ready"}, int'(req_ready), 0);
        check({tag, "_err_len"}, int'(err_len), 0);
        check({tag, "_baud_tick"}, int'(baud_tick), 0);
    endtask

    initial begin
        int e0, loads, readies, len, r;
        logic [7:0] b0, held;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        reset = 1'b0;

        // single packet A5,3C from requester 0
        tmp_q = '{8'hA5, 8'h3C};
        gen_pkt(0);
        wait_done("t1");
        check("t1_busy_len", last_busy_len, 10);

        // both requesters continuously valid, 1-byte packets
        tmp_q = '{8'h11};
        gen_pkt(0); gen_pkt(0);
        tmp_q = '{8'h22};
        gen_pkt(1); gen_pkt(1);
        wait_done("t2");

        // 6-byte packet on requester 1 split at MAX_LEN
        e0 = err_total;
        tmp_q.delete();
        for (int k = 0; k < 6; k++) tmp_q.push_back(8'($urandom));
        gen_pkt(1);
        wait_done("t3");
        check("t3_err_pulses", err_total - e0, 1);

        // serializer stalls for 100 cycles mid-payload
        tmp_q.delete();
        for (int k = 0; k < 4; k++) tmp_q.push_back(8'($urandom));
        b0 = tmp_q[0];
        gen_pkt(0);
        wait_ready(0, "t4");
        ser_mode = 2;
        @(negedge clk);
        held = ser_data;
        check("t4_held_byte", int'(held), int'(b0));
        loads = 0; readies = 0;
        repeat (100) begin
            if (ser_load) loads++;
            if (req_ready != '0) readies++;
            @(negedge clk);
        end
        check("t4_loads", loads, 0);
        check("t4_readies", readies, 0);
        check("t4_ser_data", int'(ser_data), int'(held));
        check("t4_busy", int'(busy), 1);
        ser_mode = 0;
        wait_done("t4");

        // reset during payload aborts the packet and clears the rr pointer
        tmp_q = '{8'h5A, 8'hC3, 8'h0F};
        gen_pkt(0);
        wait_ready(0, "t5");
        reset = 1'b1;
        flush = 1;
        #1;
        check_reset_outputs("t5");
        repeat (2) @(negedge clk);
        for (int k = 0; k < N; k++) begin
            pay_q[k].delete(); last_q[k].delete(); first_q[k].delete();
            exp_q[k].delete(); len_q[k].delete(); trunc_q[k].delete();
        end
        flush = 0;
        @(negedge clk);
        reset = 1'b0;
        tmp_q = '{8'h66, 8'h77};
        gen_pkt(1);
        gen_pkt(0);
        wait_done("t5");

        // randomized traffic with valid gaps and random serializer readiness
        gap_en = 1;
        ser_mode = 1;
        for (int p = 0; p < 30; p++) begin
            r = $urandom_range(0, N-1);
            len = $urandom_range(1, 9);
            tmp_q.delete();
            for (int k = 0; k < len; k++) tmp_q.push_back(8'($urandom));
            gen_pkt(r);
        end
        wait_done("rand");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
